// File: rtl/mac_pkg.sv
// Shared types, default widths and saturation bounds for the MAC accumulator slice.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} mac_acc_state_t;

  localparam int MAC_IN_W_DEF  = 16;
  localparam int MAC_ACC_W_DEF = 22;

  // Bounds are returned in 64 bits; callers keep the low `width` bits.
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return ~sat_max(width);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed adder with overflow flag.
// Defining MAC_ACC_SAT_EN clamps an overflowing sum to the signed range; otherwise it wraps.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int W = MAC_ACC_W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W-1:0] raw;

  assign raw   = a_i + b_i;
  assign ovf_o = (a_i[W-1] == b_i[W-1]) && (raw[W-1] != a_i[W-1]);

`ifdef MAC_ACC_SAT_EN
  localparam logic [63:0] MAX_V = sat_max(W);
  localparam logic [63:0] MIN_V = sat_min(W);

  // Operands share a sign on overflow, so a_i's sign picks the rail.
  assign sum_o = ovf_o ? (a_i[W-1] ? MIN_V[W-1:0] : MAX_V[W-1:0]) : raw;
`else
  assign sum_o = raw;
`endif

endmodule

// File: rtl/mac_acc_seq.sv
// Sequenced signed accumulator: sums len products, then holds the result until taken.
// Overflow handling (wrap or clamp) is selected by MAC_ACC_SAT_EN in mac_sat_add.
module mac_acc_seq
  import mac_pkg::*;
#(
  parameter int IN_W    = MAC_IN_W_DEF,
  parameter int ACC_W   = MAC_ACC_W_DEF,
  parameter int LEN_MAX = 64,
  parameter int CNT_W   = $clog2(LEN_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LEN_MAX_C = CNT_W'(LEN_MAX);

  mac_acc_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;

  logic [CNT_W-1:0] len_clamped;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  assign len_clamped = (len > LEN_MAX_C) ? LEN_MAX_C : len;
  assign addend      = ACC_W'($signed(in_data));

  mac_sat_add #(.W(ACC_W)) u_add (
    .a_i   (acc_q),
    .b_i   (addend),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = len_clamped;
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (len_clamped == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = '0;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | add_ovf;
          // Result is registered alongside the final add so it appears one cycle after the last beat.
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = sum;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// Scoreboard bench: a 22-bit and an 18-bit accumulator driven in lockstep, results checked on handshake.
module tb_mac_acc_seq;

  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic             out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, ovf_a, busy_a;
  logic [21:0] out_data_a;
  logic        in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [17:0] out_data_b;

  typedef struct {
    int data;
    bit ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mac_acc_seq #(.IN_W(16), .ACC_W(22), .LEN_MAX(64)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .ovf(ovf_a), .busy(busy_a)
  );

  mac_acc_seq #(.IN_W(16), .ACC_W(18), .LEN_MAX(64)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .ovf(ovf_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int da, input bit oa, input int db, input bit ob);
    exp_t e;
    e.data = da; e.ovf = oa; q_a.push_back(e);
    e.data = db; e.ovf = ob; q_b.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_a && out_ready) begin
      if (q_a.size() == 0) begin
        check("unexpected_result_a", 1, 0);
      end else begin
        e = q_a.pop_front();
        $display("result a: data=%0d ovf=%0d exp_data=%0d exp_ovf=%0d",
                 $signed(out_data_a), ovf_a, e.data, e.ovf);
        check("data_a", $signed(out_data_a), e.data);
        check("ovf_a", int'(ovf_a), int'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        check("unexpected_result_b", 1, 0);
      end else begin
        e = q_b.pop_front();
        $display("result b: data=%0d ovf=%0d exp_data=%0d exp_ovf=%0d",
                 $signed(out_data_b), ovf_b, e.data, e.ovf);
        check("data_b", $signed(out_data_b), e.data);
        check("ovf_b", int'(ovf_b), int'(e.ovf));
      end
    end
  end

  task automatic do_start(input int l);
    start = 1'b1;
    len   = CNT_W'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input int d);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(d);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready_a) begin
        got = 1'b1;
        break;
      end
    end
    check("beat_accepted", int'(got), 1);
    check("no_early_valid", int'(out_valid_a), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_a && !out_valid_a) begin
        got = 1'b1;
        break;
      end
    end
    check("return_to_idle", int'(got), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;

    // Reset state
    @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_in_ready", int'(in_ready_a), 0);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_out_data", int'(out_data_a), 0);
    check("rst_ovf", int'(ovf_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Basic sum; stray in_valid in IDLE must not be consumed
    push(114, 0, 114, 0);
    in_valid = 1'b1;
    in_data  = 16'(500);
    repeat (2) @(posedge clk);
    #1;
    do_start(4);
    send(10); send(-3); send(7); send(100);
    @(negedge clk);
    check("latency_valid", int'(out_valid_a), 1);
    wait_idle();

    // Input gaps, output backpressure, start during DONE
    out_ready = 1'b0;
    push(15, 0, 15, 0);
    do_start(3);
    send(5);
    @(posedge clk); #1;
    send(5);
    @(posedge clk); #1;
    send(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid_a), 1);
      check("hold_data", $signed(out_data_a), 15);
    end
    @(posedge clk); #1;
    start = 1'b1;
    len   = CNT_W'(2);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_in_done_valid", int'(out_valid_a), 1);
    check("start_in_done_data", $signed(out_data_a), 15);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_at_handshake_ignored", int'(busy_a), 0);
    @(posedge clk); #1;

    // Zero-length operation
    push(0, 0, 0, 0);
    do_start(0);
    @(negedge clk);
    check("len0_valid", int'(out_valid_a), 1);
    wait_idle();

    // Length clamp: 100 requested, 64 taken
    push(64, 0, 64, 0);
    do_start(100);
    in_valid = 1'b1;
    in_data  = 16'(1);
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (out_valid_a) begin
        got = 1'b1;
        break;
      end
      if (in_ready_a) n++;
    end
    in_valid = 1'b0;
    check("clamp_beats", n, 64);
    check("clamp_done", int'(got), 1);
    wait_idle();

    // Positive overflow in the 18-bit build
`ifdef MAC_ACC_SAT_EN
    push(163835, 0, 131071, 1);
`else
    push(163835, 0, -98309, 1);
`endif
    do_start(5);
    repeat (5) send(32767);
    wait_idle();

    // Full-length negative run
`ifdef MAC_ACC_SAT_EN
    push(-2097152, 0, -131072, 1);
`else
    push(-2097152, 0, 0, 1);
`endif
    do_start(64);
    repeat (64) send(-32768);
    wait_idle();

    // Sticky ovf must clear on the next start
    push(1, 0, 1, 0);
    do_start(1);
    send(1);
    wait_idle();

    // Reset mid-operation abandons the result
    do_start(5);
    send(1); send(1); send(1);
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_in_ready", int'(in_ready_a), 0);
    check("midrst_out_valid", int'(out_valid_a), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_result", int'(out_valid_a), 0);
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
